// File: rtl/clock_pkg.sv
// clock_pkg: shared defaults and divisor encodings for the clock divider
package clock_pkg;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_RESET_DIV = 2;
  localparam int DIV_HALT      = 0;
  localparam int DIV_STROBE    = 1;
endpackage

// File: rtl/clock_divider_channel.sv
// clock_divider_channel: one divided-clock channel with glitch-free divisor reload
module clock_divider_channel import clock_pkg::*; #(
  parameter int counterWidth = DEF_WIDTH,
  parameter int resetDivisor = DEF_RESET_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [counterWidth-1:0] divisor,
  input  logic                    load,
  input  logic                    sync,
  output logic                    clkOut,
  output logic                    tick,
  output logic                    pending
);
  localparam logic [counterWidth-1:0] L_HALT   = counterWidth'(DIV_HALT);
  localparam logic [counterWidth-1:0] L_STROBE = counterWidth'(DIV_STROBE);
  localparam logic [counterWidth-1:0] L_RESET  = counterWidth'(resetDivisor);
  logic [counterWidth-1:0] r_cnt, r_div, r_pend, w_cnt_n, w_div_n;
  logic r_valid, r_run, r_clk, r_tick, w_idle, w_wrap, w_apply;
  // Outputs are computed from next-state values so they stay registered yet cycle-aligned with cnt.
  always_comb begin
    w_idle  = !enable || !r_run || r_div == L_HALT;
    w_wrap  = sync || r_cnt == r_div - L_STROBE;
    w_apply = r_valid && (w_idle || w_wrap);
    w_div_n = w_apply ? r_pend : r_div;
    w_cnt_n = (w_idle || w_wrap) ? '0 : r_cnt + L_STROBE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt   <= '0;
      r_div   <= L_RESET;
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_run   <= 1'b0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_pend  <= load ? divisor : r_pend;
      r_valid <= load || (r_valid && !w_apply);
      r_run   <= enable;
      r_clk   <= enable && w_div_n > L_STROBE && w_cnt_n < (w_div_n >> 1);
      r_tick  <= enable && w_div_n != L_HALT && w_cnt_n == '0;
    end
  assign clkOut  = r_clk;
  assign tick    = r_tick;
  assign pending = r_valid;
endmodule

// File: rtl/clock_divider.sv
// clock_divider: array of independent divided-clock channels sharing one sync
module clock_divider import clock_pkg::*; #(
  parameter int numChannels  = DEF_CHANNELS,
  parameter int counterWidth = DEF_WIDTH,
  parameter int resetDivisor = DEF_RESET_DIV
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [numChannels-1:0]              enable,
  input  logic [numChannels*counterWidth-1:0] divisor,
  input  logic [numChannels-1:0]              load,
  input  logic                                sync,
  output logic [numChannels-1:0]              clkOut,
  output logic [numChannels-1:0]              tick,
  output logic [numChannels-1:0]              pending
);
  genvar c;
  for (c = 0; c < numChannels; c++) begin : g_ch
    clock_divider_channel #(
      .counterWidth(counterWidth),
      .resetDivisor(resetDivisor)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable[c]),
      .divisor(divisor[c*counterWidth +: counterWidth]),
      .load   (load[c]),
      .sync   (sync),
      .clkOut (clkOut[c]),
      .tick   (tick[c]),
      .pending(pending[c])
    );
  end
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed checks of division, reload, sync, enable and reset
module tb_clock_divider;
  logic clk = 1'b0, reset = 1'b1, sync = 1'b0;
  logic [3:0] enable = '0, load = '0, clkOut, tick, pending;
  logic [31:0] divisor = '0;
  int n_cmp = 0, n_bad = 0;
  clock_divider dut (
    .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
    .load(load), .sync(sync), .clkOut(clkOut), .tick(tick), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  // Returns at the negedge observing cnt=0 of the first period at the new divisor.
  task automatic prog(input int ch, input logic [7:0] val);
    enable[ch] = 1'b0;
    load[ch] = 1'b1;
    divisor[ch*8 +: 8] = val;
    cyc;
    load[ch] = 1'b0;
    chk("prog_pend_set", pending[ch], 1);
    cyc;
    chk("prog_pend_clr", pending[ch], 0);
    enable[ch] = 1'b1;
    cyc;
  endtask
  initial begin
    #12;
    chk("rst_clk", clkOut, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pend", pending, 0);
    @(negedge clk);
    reset = 1'b0;
    enable[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc;
      chk("n2", {clkOut[0], tick[0]}, {k % 2 == 0, k % 2 == 0});
    end
    prog(0, 8'd5);
    for (int k = 0; k < 500; k++) begin
      chk("n5", {clkOut[0], tick[0]}, {k % 5 < 2, k % 5 == 0});
      cyc;
    end
    prog(0, 8'd4);
    chk("ld_c0", {clkOut[0], tick[0]}, 2'b11);
    cyc;
    chk("ld_c1", {clkOut[0], tick[0]}, 2'b10);
    load[0] = 1'b1;
    divisor[7:0] = 8'd7;
    cyc;
    load[0] = 1'b0;
    chk("ld_pend2", pending[0], 1);
    chk("ld_c2", {clkOut[0], tick[0]}, 2'b00);
    cyc;
    chk("ld_pend3", pending[0], 1);
    chk("ld_c3", {clkOut[0], tick[0]}, 2'b00);
    cyc;
    chk("ld_pend_wrap", pending[0], 0);
    for (int k = 0; k < 14; k++) begin
      chk("n7", {clkOut[0], tick[0]}, {k % 7 < 3, k % 7 == 0});
      cyc;
    end
    prog(0, 8'd6);
    prog(1, 8'd4);
    cyc;
    cyc;
    sync = 1'b1;
    cyc;
    sync = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("sync_pair", {clkOut[1:0], tick[1:0]},
          {k % 4 < 2, k % 6 < 3, k % 4 == 0, k % 6 == 0});
      cyc;
    end
    cyc;
    load[0] = 1'b1;
    divisor[7:0] = 8'd3;
    cyc;
    load[0] = 1'b0;
    sync = 1'b1;
    chk("sync_pend_before", pending[0], 1);
    cyc;
    sync = 1'b0;
    chk("sync_pend_after", pending[0], 0);
    for (int k = 0; k < 6; k++) begin
      chk("n3_sync", {clkOut[0], tick[0]}, {k % 3 < 1, k % 3 == 0});
      cyc;
    end
    prog(2, 8'd0);
    prog(3, 8'd1);
    for (int k = 0; k < 5; k++) begin
      chk("halt_n0", {clkOut[2], tick[2]}, 2'b00);
      chk("strobe_n1", {clkOut[3], tick[3]}, 2'b01);
      cyc;
    end
    prog(0, 8'd9);
    cyc;
    cyc;
    load[1] = 1'b1;
    divisor[15:8] = 8'd9;
    cyc;
    load[1] = 1'b0;
    chk("pre_rst_pend", pending[1], 1);
    chk("pre_rst_tick", tick[3], 1);
    #2 reset = 1'b1;
    #1;
    chk("async_clk", clkOut, 0);
    chk("async_tick", tick, 0);
    chk("async_pend", pending, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc;
      chk("post_rst_n2", {clkOut, tick}, (k % 2 == 0) ? 8'hFF : 8'h00);
    end
    chk("post_rst_pend", pending, 0);
    prog(0, 8'd8);
    cyc;
    cyc;
    cyc;
    chk("en_c3", {clkOut[0], tick[0]}, 2'b10);
    enable[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("en_off", {clkOut[0], tick[0]}, 2'b00);
    end
    enable[0] = 1'b1;
    cyc;
    for (int k = 0; k < 16; k++) begin
      chk("n8_reen", {clkOut[0], tick[0]}, {k % 8 < 4, k % 8 == 0});
      cyc;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter numChannels, default 4: number of independent divided-clock channels (1..16).
REQ-002 Parameter counterWidth, default 8: width of each channel's divisor and period counter (2..16).
REQ-003 Parameter resetDivisor, default 2: divisor every channel holds after reset, in range 0..2^counterWidth-1.
REQ-004 clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 enable  input  numChannels: per-channel run enable, level-sensitive.
REQ-007 divisor  input  numChannels*counterWidth: packed divisor bus; channel i occupies bits [i*counterWidth +: counterWidth].
REQ-008 load  input  numChannels: per-channel single-cycle request to capture that channel's divisor slice.
REQ-009 sync  input  1: single-cycle request to phase-align all enabled channels.
REQ-010 clkOut  output  numChannels: registered divided clock per channel.
REQ-011 tick  output  numChannels: registered one-cycle strobe at the start of each output period.
REQ-012 pending  output  numChannels: high while a loaded divisor awaits application.

Function
REQ-013 Each channel SHALL hold an active divisor N, a pending divisor P with valid flag, and a period counter cnt counting 0..N-1, then wrapping to 0.
REQ-014 For N>=2 and enable high: clkOut SHALL be 1 while cnt < floor(N/2), else 0; it is high floor(N/2) cycles and low ceil(N/2) cycles per period.
REQ-015 tick SHALL be 1 exactly in cycles where cnt==0 and the channel is enabled with N>=1.
REQ-016 clkOut and tick SHALL be registered, cycle-aligned with cnt, with no combinational path from any input.
REQ-017 N==1: tick high every enabled cycle; clkOut held 0.
REQ-018 N==0: channel halted; cnt held 0; clkOut and tick held 0.
REQ-019 load[i] high SHALL capture the divisor slice into P and set pending[i] the following cycle.
REQ-020 A later load before application SHALL overwrite P; the last value wins.
REQ-021 P SHALL be applied, and pending cleared, on the cycle cnt wraps from N-1 to 0, so ratio changes never produce a truncated high or low phase.
REQ-022 If a channel is disabled or halted (N==0), P SHALL apply on the cycle after load.
REQ-023 load coinciding with a wrap SHALL apply the newly loaded value at the next wrap, not the current one.
REQ-024 enable[i] low SHALL force cnt=0, clkOut=0 and tick=0 from the next cycle.
REQ-025 Re-enable SHALL start a period at cnt=0 with tick=1 in the first enabled cycle.
REQ-026 sync high SHALL force cnt=0 next cycle on every enabled channel.
REQ-027 A pending divisor SHALL be applied at sync; sync counts as a wrap.
REQ-028 sync SHALL take priority over normal counting when it coincides with a natural wrap.
REQ-029 Channels SHALL be fully independent except for the shared sync.

Reset
REQ-030 While reset is high, every channel SHALL be set, asynchronously and without waiting for clk: cnt=0, N=resetDivisor, P=0, pending=0, clkOut=0, tick=0.
REQ-031 Reset deasserted mid-period SHALL resume from the REQ-030 state, with the first enabled cycle behaving per REQ-025.

Structure
REQ-032 A shared package clock_pkg SHALL hold default parameter constants and the N==0 halt / N==1 strobe encodings.
REQ-033 Per-channel logic SHALL live in sub-module clock_divider_channel, instantiated numChannels times by a generate loop.
REQ-034 The top level SHALL contain only bus slicing and sync fan-out.

Verification
REQ-035 Reset, enable=1 on channel 0, counterWidth=8, N=2 -> clkOut0 toggles every cycle; tick0 on every second cycle.
REQ-036 N=5 -> clkOut high 2 cycles, low 3 cycles; tick once per 5 cycles; 100 periods checked.
REQ-037 Running at N=4, load divisor=7 at cnt=1 -> pending=1; current period completes 4 cycles; next period is 7 cycles; pending clears at the wrap.
REQ-038 Channel 0 at N=6 and channel 1 at N=4, pulse sync at arbitrary offset -> both tick together next cycle; N=0 -> outputs stay 0; N=1 -> tick constantly high.
REQ-039 Assert reset asynchronously mid-period with N=9 loaded -> all outputs 0 immediately; divisor returns to resetDivisor.
REQ-040 Toggle enable low for 3 cycles at cnt=3 of N=8 -> outputs 0 during disable; tick=1 and clkOut=1 in the first re-enabled cycle.
